// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the 6502 interrupt sequencer.
// States, address/data select codes, interrupt sources and default vectors.
package interrupt_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RES_HOLD,
        ST_C0,
        ST_C1,
        ST_C2,
        ST_C3,
        ST_C4,
        ST_C5,
        ST_C6
    } state_e;

    typedef enum logic [1:0] {
        INT_SRC_NONE = 2'd0,
        INT_SRC_IRQ  = 2'd1,
        INT_SRC_NMI  = 2'd2,
        INT_SRC_RES  = 2'd3
    } int_src_e;

    localparam logic [1:0] ADDR_SEL_PC    = 2'd0;
    localparam logic [1:0] ADDR_SEL_STACK = 2'd1;
    localparam logic [1:0] ADDR_SEL_VEC   = 2'd2;

    localparam logic [1:0] DATA_SEL_PCH = 2'd0;
    localparam logic [1:0] DATA_SEL_PCL = 2'd1;
    localparam logic [1:0] DATA_SEL_P   = 2'd2;

    localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
    localparam logic [15:0] VEC_RES_DEF = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

    // Sequence cycle number reported to the core; 0 outside the sequence.
    function automatic logic [2:0] cycle_num(state_e s);
        logic [2:0] c;
        c = 3'd0;
        case (s)
            ST_C1:   c = 3'd1;
            ST_C2:   c = 3'd2;
            ST_C3:   c = 3'd3;
            ST_C4:   c = 3'd4;
            ST_C5:   c = 3'd5;
            ST_C6:   c = 3'd6;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    // Read cycles are the only ones rdy is allowed to stall.
    function automatic logic is_read_cycle(state_e s);
        return (s == ST_C0) || (s == ST_C1) || (s == ST_C5) || (s == ST_C6);
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Control bundle between the interrupt sequencer and the 6502 core.
// slave: the sequencer side; master: the core/datapath side.
interface interrupt_sequencer_if;
    logic        irq;
    logic        nmi;
    logic        rdy;
    logic        i_flag;
    logic        boundary;
    logic        int_take;
    logic        seq_busy;
    logic [2:0]  seq_cycle;
    logic        rw;
    logic [1:0]  addr_sel;
    logic [15:0] vector_addr;
    logic [1:0]  data_sel;
    logic        b_flag;
    logic        sp_dec;
    logic        pc_load_lo;
    logic        pc_load_hi;
    logic        set_i;
    logic [1:0]  int_src;

    modport slave (
        input  irq, nmi, rdy, i_flag, boundary,
        output int_take, seq_busy, seq_cycle, rw, addr_sel, vector_addr,
               data_sel, b_flag, sp_dec, pc_load_lo, pc_load_hi, set_i, int_src
    );

    modport master (
        output irq, nmi, rdy, i_flag, boundary,
        input  int_take, seq_busy, seq_cycle, rw, addr_sel, vector_addr,
               data_sel, b_flag, sp_dec, pc_load_lo, pc_load_hi, set_i, int_src
    );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// Request conditioning: optional 2-flop synchronizers on irq/nmi (INT_SYNC_EN),
// NMI rising-edge detect and a sticky NMI latch cleared by the sequencer.
module nmi_edge_detect
    import interrupt_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic nmi_in,
    input  logic clr,
    output logic irq_o,
    output logic nmi_pend,
    output logic nmi_latch
);
    logic irq_s;
    logic nmi_s;

`ifdef INT_SYNC_EN
    logic irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;
    logic nmi_s1_q, nmi_s1_d, nmi_s2_q, nmi_s2_d;

    // Two-stage shift of the raw requests into the clock domain.
    always_comb begin
        irq_s1_d = irq_in;
        irq_s2_d = irq_s1_q;
        nmi_s1_d = nmi_in;
        nmi_s2_d = nmi_s1_q;
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1_q <= 1'b0;
            irq_s2_q <= 1'b0;
            nmi_s1_q <= 1'b0;
            nmi_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= irq_s1_d;
            irq_s2_q <= irq_s2_d;
            nmi_s1_q <= nmi_s1_d;
            nmi_s2_q <= nmi_s2_d;
        end
    end

    assign irq_s = irq_s2_q;
    assign nmi_s = nmi_s2_q;
`else
    assign irq_s = irq_in;
    assign nmi_s = nmi_in;
`endif

    logic nmi_prev_q, nmi_prev_d;
    logic latch_q, latch_d;
    logic edge_seen;

    // A new edge wins over a clear landing in the same cycle so it is never lost.
    always_comb begin
        edge_seen  = nmi_s & ~nmi_prev_q;
        nmi_prev_d = nmi_s;
        latch_d    = edge_seen | (latch_q & ~clr);
    end

    // Edge history and pending-NMI latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_prev_q <= 1'b0;
            latch_q    <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_prev_d;
            latch_q    <= latch_d;
        end
    end

    assign irq_o     = irq_s;
    assign nmi_pend  = latch_q | edge_seen;   // includes an edge arriving this cycle
    assign nmi_latch = latch_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 hardware interrupt sequencer: recognises RES/NMI/IRQ and runs the
// 7-cycle push-PC/push-P/load-vector sequence, owning the datapath controls
// until the new PC is loaded. Optional macro INT_SYNC_EN adds input synchronizers.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
    parameter logic [15:0] VEC_RES = VEC_RES_DEF,
    parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF
) (
    input  logic                  clk,
    input  logic                  res,
    interrupt_sequencer_if.slave  bus
);
    state_e   state_q, state_d;
    int_src_e src_q, src_d;

    logic irq_s, nmi_pend, nmi_latch, nmi_clr, take;

    // NMI is consumed only when an NMI-sourced sequence commits its vector low byte.
    assign nmi_clr = (state_q == ST_C5) && bus.rdy && (src_q == INT_SRC_NMI);

    nmi_edge_detect u_nmi (
        .clk       (clk),
        .rst       (res),
        .irq_in    (bus.irq),
        .nmi_in    (bus.nmi),
        .clr       (nmi_clr),
        .irq_o     (irq_s),
        .nmi_pend  (nmi_pend),
        .nmi_latch (nmi_latch)
    );

    assign take = (state_q == ST_IDLE) && bus.boundary &&
                  (nmi_latch || (irq_s && !bus.i_flag));

    // Next state: write cycles always advance, read cycles wait for rdy.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        case (state_q)
            ST_IDLE: if (take) begin
                state_d = ST_C0;
                src_d   = nmi_latch ? INT_SRC_NMI : INT_SRC_IRQ;
            end
            ST_RES_HOLD: begin
                state_d = ST_C0;
                src_d   = INT_SRC_RES;
            end
            ST_C0: if (bus.rdy) state_d = ST_C1;
            ST_C1: if (bus.rdy) state_d = ST_C2;
            ST_C2: state_d = ST_C3;
            ST_C3: state_d = ST_C4;
            ST_C4: begin
                state_d = ST_C5;
                // Late-arriving NMI steals the vector fetch of an IRQ sequence.
                if (src_q == INT_SRC_IRQ && nmi_pend) src_d = INT_SRC_NMI;
            end
            ST_C5: if (bus.rdy) state_d = ST_C6;
            ST_C6: if (bus.rdy) begin
                state_d = ST_IDLE;
                src_d   = INT_SRC_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = INT_SRC_NONE;
            end
        endcase
    end

    // State register; res forces RES_HOLD immediately, aborting any sequence.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ST_RES_HOLD;
            src_q   <= INT_SRC_NONE;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
        end
    end

    logic        busy, rw, sp_dec, pc_lo, pc_hi, set_i;
    logic [1:0]  addr_sel, data_sel;
    logic [15:0] vec_base, vector_addr;
    logic        push_rw;

    // Reset sequence runs the stack cycles as reads so nothing is written.
    assign push_rw = (src_q == INT_SRC_RES);

    // Vector selected by the source of the running sequence.
    always_comb begin
        case (src_q)
            INT_SRC_RES: vec_base = VEC_RES;
            INT_SRC_NMI: vec_base = VEC_NMI;
            default:     vec_base = VEC_IRQ;
        endcase
    end

    // Per-cycle datapath controls.
    always_comb begin
        busy        = 1'b1;
        rw          = 1'b1;
        addr_sel    = ADDR_SEL_PC;
        data_sel    = DATA_SEL_PCH;
        vector_addr = 16'h0000;
        sp_dec      = 1'b0;
        pc_lo       = 1'b0;
        pc_hi       = 1'b0;
        set_i       = 1'b0;
        case (state_q)
            ST_C0, ST_C1: ;
            ST_C2: begin
                addr_sel = ADDR_SEL_STACK;
                rw       = push_rw;
                data_sel = DATA_SEL_PCH;
                sp_dec   = 1'b1;
            end
            ST_C3: begin
                addr_sel = ADDR_SEL_STACK;
                rw       = push_rw;
                data_sel = DATA_SEL_PCL;
                sp_dec   = 1'b1;
            end
            ST_C4: begin
                addr_sel = ADDR_SEL_STACK;
                rw       = push_rw;
                data_sel = DATA_SEL_P;
                sp_dec   = 1'b1;
                set_i    = 1'b1;
            end
            ST_C5: begin
                addr_sel    = ADDR_SEL_VEC;
                vector_addr = vec_base;
                pc_lo       = 1'b1;
            end
            ST_C6: begin
                addr_sel    = ADDR_SEL_VEC;
                vector_addr = vec_base + 16'd1;
                pc_hi       = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign bus.int_take    = take;
    assign bus.seq_busy    = busy;
    assign bus.seq_cycle   = cycle_num(state_q);
    assign bus.rw          = rw;
    assign bus.addr_sel    = addr_sel;
    assign bus.vector_addr = vector_addr;
    assign bus.data_sel    = data_sel;
    assign bus.b_flag      = 1'b0;
    assign bus.sp_dec      = sp_dec;
    assign bus.pc_load_lo  = pc_lo;
    assign bus.pc_load_hi  = pc_hi;
    assign bus.set_i       = set_i;
    assign bus.int_src     = src_q;
endmodule
